aemb2_dwb_sram: RTL and testbench

// - Wishbone data-bus responder for the AEMB2 data port: a single-port word SRAM with byte-lane writes.
// - Accepts cycles from the core's data-bus master and returns read data with a single-cycle ack.
// - Provides a programmable wait-state count so benches and SoCs can stall the pipeline.
// - Sits between the core data port and on-chip data memory; big-endian lanes, MicroBlaze ordering.

---
 rtl/aemb2_dwb_sram_if.sv | 26 ++
 rtl/aemb2_dwb_sram.sv | 100 ++++++++++
 tb/tb_aemb2_dwb_sram.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/aemb2_dwb_sram_if.sv
// AEMB2 data-bus (Wishbone) bundle between the core data port and the data SRAM.
// Signal names keep the slave-side view: *_i flows master->slave, *_o flows slave->master.
interface aemb2_dwb_sram_if #(
    parameter int unsigned AEMB_DWB = 32
);
    logic [AEMB_DWB-1:2] dwb_adr_i;
    logic [3:0]          dwb_sel_i;
    logic                dwb_stb_i;
    logic                dwb_cyc_i;
    logic                dwb_wre_i;
    logic                dwb_tag_i;
    logic [31:0]         dwb_dat_i;
    logic [31:0]         dwb_dat_o;
    logic                dwb_ack_o;
    logic                dwb_err_o;

    modport master (
        output dwb_adr_i, dwb_sel_i, dwb_stb_i, dwb_cyc_i, dwb_wre_i, dwb_tag_i, dwb_dat_i,
        input  dwb_dat_o, dwb_ack_o, dwb_err_o
    );

    modport slave (
        input  dwb_adr_i, dwb_sel_i, dwb_stb_i, dwb_cyc_i, dwb_wre_i, dwb_tag_i, dwb_dat_i,
        output dwb_dat_o, dwb_ack_o, dwb_err_o
    );
endinterface

// File: rtl/aemb2_dwb_sram.sv
// AEMB2 data-bus SRAM responder: byte-lane word SRAM, programmable wait states, one-cycle ack.
// Define AEMB_DSRAM_BOUNDS_EN to error-ack addresses beyond the memory instead of aliasing them.
module aemb2_dwb_sram #(
    parameter int unsigned AEMB_DWB  = 32,
    parameter int unsigned AEMB_DSZ  = 10,
    parameter int unsigned AEMB_WAIT = 0
) (
    input logic             gclk,
    input logic             grst,
    aemb2_dwb_sram_if.slave dwb
);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic                ack_q;
    logic                err_q;
    logic [31:0]         dat_q;
    logic [31:0]         mem [2**AEMB_DSZ];

    logic                req;
    logic                oob;
    logic                commit;
    logic [AEMB_DSZ-1:0] idx;
    logic                unused_bits;

    assign req = dwb.dwb_cyc_i & dwb.dwb_stb_i;
    assign idx = dwb.dwb_adr_i[AEMB_DSZ+1:2];

`ifdef AEMB_DSRAM_BOUNDS_EN
    assign oob = |dwb.dwb_adr_i[AEMB_DWB-1:AEMB_DSZ+2];
`else
    assign oob = 1'b0;
`endif

    assign unused_bits = ^{dwb.dwb_tag_i, dwb.dwb_adr_i[AEMB_DWB-1:AEMB_DSZ+2]};

    // The edge entering ACK is the only point that touches memory; gating with grst keeps a
    // reset that lands on that edge from leaving a partial write behind.
    always_comb begin
        commit = 1'b0;
        if (grst && req) begin
            if (state_q == StIdle && AEMB_WAIT == 0) commit = 1'b1;
            if (state_q == StWait && cnt_q == 4'd1)  commit = 1'b1;
        end
    end

    always_ff @(posedge gclk) begin
        if (commit && dwb.dwb_wre_i && !oob) begin
            for (int i = 0; i < 4; i++) begin
                if (dwb.dwb_sel_i[i]) mem[idx][8*i +: 8] <= dwb.dwb_dat_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'h0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req && AEMB_WAIT != 0) begin
                        state_q <= StWait;
                        cnt_q   <= 4'(AEMB_WAIT);
                    end
                end
                StWait: begin
                    if (!req) begin
                        state_q <= StIdle;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StAck:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (commit) begin
                state_q <= StAck;
                cnt_q   <= 4'd0;
                ack_q   <= 1'b1;
                err_q   <= oob;
                if (oob)                  dat_q <= 32'h0;
                else if (!dwb.dwb_wre_i)  dat_q <= mem[idx];
            end
        end
    end

    assign dwb.dwb_ack_o = ack_q;
    assign dwb.dwb_err_o = err_q;
    assign dwb.dwb_dat_o = dat_q;

endmodule

// File: tb/tb_aemb2_dwb_sram.sv
// Scoreboard bench for aemb2_dwb_sram: a master issues directed and random accesses against a
// word/byte-mask memory model; a negedge monitor pops the expected response on every ack.
module tb_aemb2_dwb_sram;

    localparam int unsigned TB_DWB  = 32;
    localparam int unsigned TB_DSZ  = 10;
    localparam int unsigned TB_WAIT = 3;
`ifdef AEMB_DSRAM_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct {
        int          cyc;
        bit          chk;
        logic [31:0] data;
        logic [31:0] mask;
        bit          err;
    } exp_t;

    logic gclk;
    logic grst;
    int   cyc_n    = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   last_ack = -100;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mdata  [1024];
    logic [3:0]  mknown [1024];

    aemb2_dwb_sram_if #(.AEMB_DWB(TB_DWB)) bus ();

    aemb2_dwb_sram #(
        .AEMB_DWB  (TB_DWB),
        .AEMB_DSZ  (TB_DSZ),
        .AEMB_WAIT (TB_WAIT)
    ) dut (
        .gclk (gclk),
        .grst (grst),
        .dwb  (bus)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;
    always @(posedge gclk) cyc_n <= cyc_n + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc_n);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge gclk) begin
        if (grst && bus.dwb_ack_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_cycle", cyc_n, mon_e.cyc);
                check("err", {31'd0, bus.dwb_err_o}, {31'd0, mon_e.err});
                if (mon_e.chk) check("rdata", bus.dwb_dat_o & mon_e.mask, mon_e.data & mon_e.mask);
            end
        end
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] l);
        return {{8{l[3]}}, {8{l[2]}}, {8{l[1]}}, {8{l[0]}}};
    endfunction

    task automatic drive(input logic [29:0] adr, input logic [3:0] sel, input bit wre,
                         input logic [31:0] dat);
        bus.dwb_adr_i = adr;
        bus.dwb_sel_i = sel;
        bus.dwb_wre_i = wre;
        bus.dwb_dat_i = dat;
        bus.dwb_tag_i = 1'($urandom);
        bus.dwb_cyc_i = 1'b1;
        bus.dwb_stb_i = 1'b1;
    endtask

    // Slave samples a request on the first edge after it is driven, except that the edge
    // right after an ack cycle is never a sampling edge.
    function automatic int sample_edge();
        return (last_ack + 2 > cyc_n + 1) ? last_ack + 2 : cyc_n + 1;
    endfunction

    // Called #1 after a posedge; returns #1 after the posedge that raised ack (or the drop).
    task automatic do_txn(input logic [29:0] adr, input logic [3:0] sel, input bit wre,
                          input logic [31:0] dat, input bit abort);
        int   s;
        int   idx;
        bit   oob;
        bit   got;
        exp_t e;
        s = sample_edge();
        drive(adr, sel, wre, dat);
        if (abort) begin
            while (cyc_n < s + 1) begin
                @(posedge gclk); #1;
            end
            if ($urandom_range(0, 1) == 0) bus.dwb_cyc_i = 1'b0;
            else                           bus.dwb_stb_i = 1'b0;
            @(posedge gclk); #1;
            last_ack = -100;
        end else begin
            idx   = int'(adr % 30'd1024);
            oob   = BOUNDS && (adr >= 30'd1024);
            e.cyc = s + int'(TB_WAIT);
            e.err = oob;
            if (oob) begin
                e.chk = 1'b1; e.data = 32'h0; e.mask = 32'hFFFF_FFFF;
            end else if (!wre) begin
                e.data = mdata[idx];
                e.mask = lane_mask(mknown[idx]);
                e.chk  = (e.mask != 32'h0);
            end else begin
                e.chk = 1'b0; e.data = 32'h0; e.mask = 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) begin
                        mdata[idx][8*i +: 8] = dat[8*i +: 8];
                        mknown[idx][i]       = 1'b1;
                    end
                end
            end
            sb_q.push_back(e);
            got = 1'b0;
            for (int i = 0; i < int'(TB_WAIT) + 8 && !got; i++) begin
                @(posedge gclk); #1;
                if (bus.dwb_ack_o) got = 1'b1;
            end
            if (got) begin
                last_ack = cyc_n;
            end else begin
                check("ack_timeout", 32'd0, 32'd1);
                last_ack = -100;
            end
        end
    endtask

    task automatic idle(input int g);
        int c;
        c = $urandom_range(0, 2);
        bus.dwb_cyc_i = (c == 1);
        bus.dwb_stb_i = (c == 2);
        repeat (g) begin
            @(posedge gclk); #1;
        end
    endtask

    initial begin
        int          s;
        int          g;
        bit          w;
        logic [29:0] a;

        for (int i = 0; i < 1024; i++) begin
            mdata[i]  = 32'h0;
            mknown[i] = 4'h0;
        end
        grst = 1'b0;
        drive(30'h0, 4'h0, 1'b0, 32'h0);
        bus.dwb_cyc_i = 1'b0;
        bus.dwb_stb_i = 1'b0;
        repeat (3) @(posedge gclk);
        #1;
        check("rst_ack", {31'd0, bus.dwb_ack_o}, 32'd0);
        check("rst_err", {31'd0, bus.dwb_err_o}, 32'd0);
        check("rst_dat", bus.dwb_dat_o, 32'h0);
        #3 grst = 1'b1;
        @(posedge gclk); #1;

        // Directed: full write/read, byte lane, aliasing or bounds, sel=0, abort.
        do_txn(30'h010, 4'hF, 1'b1, 32'h1234_5678, 1'b0);
        do_txn(30'h010, 4'hF, 1'b0, 32'h0, 1'b0);
        do_txn(30'h010, 4'h4, 1'b1, 32'hAAAA_AAAA, 1'b0);
        do_txn(30'h010, 4'hF, 1'b0, 32'h0, 1'b0);
        idle(2);
        do_txn(30'h000, 4'hF, 1'b1, 32'hCAFE_F00D, 1'b0);
        idle(1);
        do_txn(30'h400, 4'hF, 1'b0, 32'h0, 1'b0);
        do_txn(30'h400, 4'hF, 1'b1, 32'h0BAD_BEEF, 1'b0);
        do_txn(30'h000, 4'hF, 1'b0, 32'h0, 1'b0);
        do_txn(30'h010, 4'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        do_txn(30'h010, 4'h0, 1'b0, 32'h0, 1'b0);
        idle(1);
        do_txn(30'h010, 4'hF, 1'b1, 32'hDEAD_DEAD, 1'b1);
        idle(1);
        do_txn(30'h010, 4'hF, 1'b0, 32'h0, 1'b0);

        // Reset in the middle of a write's wait phase drops it without touching memory.
        idle(1);
        s = sample_edge();
        drive(30'h010, 4'hF, 1'b1, 32'h5555_5555);
        while (cyc_n < s + 1) begin
            @(posedge gclk); #1;
        end
        #3 grst = 1'b0;
        #1;
        check("midrst_ack", {31'd0, bus.dwb_ack_o}, 32'd0);
        check("midrst_dat", bus.dwb_dat_o, 32'h0);
        check("midrst_err", {31'd0, bus.dwb_err_o}, 32'd0);
        bus.dwb_cyc_i = 1'b0;
        bus.dwb_stb_i = 1'b0;
        repeat (2) @(posedge gclk);
        #4 grst = 1'b1;
        @(posedge gclk); #1;
        last_ack = -100;
        do_txn(30'h010, 4'hF, 1'b0, 32'h0, 1'b0);

        // Random traffic over a small window plus upper-bit aliases.
        for (int n = 0; n < 300; n++) begin
            a = 30'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) a = a | (30'd1 << $urandom_range(10, 29));
            w = 1'($urandom);
            do_txn(a, 4'($urandom), w, $urandom,
                   w && (TB_WAIT >= 2) && ($urandom_range(0, 9) == 0));
            g = $urandom_range(0, 2);
            if (g > 0) idle(g);
        end

        idle(1);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge gclk);
        if (sb_q.size() != 0) check("missing_ack", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
